// File: rtl/mux6_1_reg.sv
// rtl/mux6_1_reg.sv - registered 6-to-1 ALU result multiplexer with error flag and index
module mux6_1_reg #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada0,
  input  logic [LARGURA-1:0] entrada1,
  input  logic [LARGURA-1:0] entrada2,
  input  logic [LARGURA-1:0] entrada3,
  input  logic [LARGURA-1:0] entrada4,
  input  logic [LARGURA-1:0] entrada5,
  input  logic [0:3]         seletor,
  input  logic               habilita,
  output logic [LARGURA-1:0] saida,
  output logic               erro,
  output logic [2:0]         indice
);

  logic [LARGURA-1:0] w_dado;
  logic [2:0]         w_indice;
  logic               w_erro;

  logic [LARGURA-1:0] r_saida;
  logic [2:0]         r_indice;
  logic               r_erro;

  // seletor[0] is the MSB, so the literals below read in the usual MSB-first order.
  // Plain case compares all four states: any X/Z bit falls through to the error arm.
  always_comb begin
    w_dado   = '0;
    w_indice = 3'd7;
    w_erro   = 1'b1;
    case (seletor)
      4'b0000: begin w_dado = entrada0; w_indice = 3'd0; w_erro = 1'b0; end
      4'b0001: begin w_dado = entrada1; w_indice = 3'd1; w_erro = 1'b0; end
      4'b0010: begin w_dado = entrada2; w_indice = 3'd2; w_erro = 1'b0; end
      4'b0110: begin w_dado = entrada3; w_indice = 3'd3; w_erro = 1'b0; end
      4'b0111: begin w_dado = entrada4; w_indice = 3'd4; w_erro = 1'b0; end
      4'b1100: begin w_dado = entrada5; w_indice = 3'd5; w_erro = 1'b0; end
      default: begin
        w_dado   = '0;
        w_indice = 3'd7;
        w_erro   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_saida  <= '0;
      r_erro   <= 1'b0;
      r_indice <= 3'd0;
    end else if (habilita) begin
      r_saida  <= w_dado;
      r_erro   <= w_erro;
      r_indice <= w_indice;
    end
  end

  assign saida  = r_saida;
  assign erro   = r_erro;
  assign indice = r_indice;

endmodule

// File: tb/tb_mux6_1_reg.sv
// tb/tb_mux6_1_reg.sv - directed vector table plus randomized model check for mux6_1_reg
module tb_mux6_1_reg;

  typedef struct packed {
    logic            rst;
    logic            en;
    logic [3:0]      sel;
    logic [5:0][7:0] dat;
    logic [7:0]      es;
    logic            ee;
    logic [2:0]      ei;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [0:3] seletor;
  logic [7:0] d8 [6];
  logic       d1 [6];

  logic [7:0] s8;
  logic       e8;
  logic [2:0] i8;
  logic       s1;
  logic       e1;
  logic [2:0] i1;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl[$];

  always #5 clock = ~clock;

  mux6_1_reg #(.LARGURA(8)) u8 (
    .clock(clock), .reset(reset),
    .entrada0(d8[0]), .entrada1(d8[1]), .entrada2(d8[2]),
    .entrada3(d8[3]), .entrada4(d8[4]), .entrada5(d8[5]),
    .seletor(seletor), .habilita(habilita),
    .saida(s8), .erro(e8), .indice(i8)
  );

  mux6_1_reg #(.LARGURA(1)) u1 (
    .clock(clock), .reset(reset),
    .entrada0(d1[0]), .entrada1(d1[1]), .entrada2(d1[2]),
    .entrada3(d1[3]), .entrada4(d1[4]), .entrada5(d1[5]),
    .seletor(seletor), .habilita(habilita),
    .saida(s1), .erro(e1), .indice(i1)
  );

  function automatic logic [5:0][7:0] d6(input logic [7:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic rst, en, input logic [3:0] sel,
                              input logic [5:0][7:0] dat, input logic [7:0] es,
                              input logic ee, input logic [2:0] ei);
    vec_t v;
    v.rst = rst; v.en = en; v.sel = sel; v.dat = dat;
    v.es = es; v.ee = ee; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  // Drive at the falling edge, capture on the rising edge, sample 1 time unit later.
  task automatic apply(input logic rst, en, input logic [3:0] sel, input logic [5:0][7:0] dat);
    @(negedge clock);
    reset    = rst;
    habilita = en;
    seletor  = sel;
    for (int k = 0; k < 6; k++) begin
      d8[k] = dat[k];
      d1[k] = dat[k][0];
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input int row, input logic [7:0] es, input logic ee, input logic [2:0] ei);
    chk("saida8", row, s8, es);
    chk("erro8", row, {7'd0, e8}, {7'd0, ee});
    chk("indice8", row, {5'd0, i8}, {5'd0, ei});
    chk("saida1", row, {7'd0, s1}, {7'd0, es[0]});
    chk("erro1", row, {7'd0, e1}, {7'd0, ee});
    chk("indice1", row, {5'd0, i1}, {5'd0, ei});
  endtask

  // Reference: table of the six supported control codes, position = operation index.
  logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  logic [7:0] m_s;
  logic       m_e;
  logic [2:0] m_i;

  task automatic model_step(input logic rst, en, input logic [3:0] sel, input logic [5:0][7:0] dat);
    int hit;
    hit = -1;
    for (int k = 0; k < 6; k++) if (codes[k] == sel) hit = k;
    if (rst) begin
      m_s = 8'd0; m_e = 1'b0; m_i = 3'd0;
    end else if (en) begin
      if (hit < 0) begin
        m_s = 8'd0; m_e = 1'b1; m_i = 3'd7;
      end else begin
        m_s = dat[hit]; m_e = 1'b0; m_i = hit[2:0];
      end
    end
  endtask

  initial begin
    logic [5:0][7:0] sweep;
    logic [5:0][7:0] ones;
    logic [5:0][7:0] rd;
    logic [3:0]      rs;
    logic            rr, re;

    reset = 1'b1; habilita = 1'b0; seletor = 4'b0000;
    for (int k = 0; k < 6; k++) begin d8[k] = 8'd0; d1[k] = 1'b0; end

    sweep = d6(8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0);
    ones  = d6(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    tbl.push_back(mk(1, 1, 4'b0010, d6(0, 0, 8'd1, 0, 0, 0), 8'd0, 0, 3'd0));
    tbl.push_back(mk(1, 1, 4'b0010, d6(0, 0, 8'd1, 0, 0, 0), 8'd0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 4'b0000, sweep, 8'd1, 0, 3'd0));
    tbl.push_back(mk(0, 1, 4'b0001, sweep, 8'd0, 0, 3'd1));
    tbl.push_back(mk(0, 1, 4'b0010, sweep, 8'd1, 0, 3'd2));
    tbl.push_back(mk(0, 1, 4'b0110, sweep, 8'd0, 0, 3'd3));
    tbl.push_back(mk(0, 1, 4'b0111, sweep, 8'd1, 0, 3'd4));
    tbl.push_back(mk(0, 1, 4'b1100, sweep, 8'd0, 0, 3'd5));
    tbl.push_back(mk(0, 1, 4'b0011, ones, 8'd0, 1, 3'd7));
    tbl.push_back(mk(0, 1, 4'b0100, ones, 8'd0, 1, 3'd7));
    tbl.push_back(mk(0, 1, 4'b0101, ones, 8'd0, 1, 3'd7));
    tbl.push_back(mk(0, 1, 4'b1000, ones, 8'd0, 1, 3'd7));
    tbl.push_back(mk(0, 1, 4'b1111, ones, 8'd0, 1, 3'd7));
    tbl.push_back(mk(0, 1, 4'b0001, d6(0, 8'h81, 0, 0, 0, 0), 8'h81, 0, 3'd1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, 4'b0000, d6(0, 0, 0, 0, 0, 0), 8'h81, 0, 3'd1));
    tbl.push_back(mk(0, 1, 4'b0110, d6(0, 0, 0, 8'hA5, 0, 0), 8'hA5, 0, 3'd3));
    tbl.push_back(mk(0, 1, 4'b1100, d6(0, 0, 0, 0, 0, 8'h3C), 8'h3C, 0, 3'd5));
    tbl.push_back(mk(1, 1, 4'b0110, ones, 8'd0, 0, 3'd0));
    tbl.push_back(mk(0, 1, 4'b0110, ones, 8'hFF, 0, 3'd3));

    foreach (tbl[r]) begin
      apply(tbl[r].rst, tbl[r].en, tbl[r].sel, tbl[r].dat);
      check_all(r, tbl[r].es, tbl[r].ee, tbl[r].ei);
    end

    // Multi-cycle: an enabled edge after an error capture recovers cleanly.
    apply(0, 1, 4'b1010, ones);
    check_all(100, 8'd0, 1, 3'd7);
    apply(0, 0, 4'b0111, ones);
    check_all(101, 8'd0, 1, 3'd7);
    apply(0, 1, 4'b0111, d6(0, 0, 0, 0, 8'h77, 0));
    check_all(102, 8'h77, 0, 3'd4);

    m_s = 8'h77; m_e = 1'b0; m_i = 3'd4;
    for (int n = 0; n < 300; n++) begin
      rr = ($urandom_range(15) == 0);
      re = ($urandom_range(3) != 0);
      rs = ($urandom_range(1) == 0) ? codes[$urandom_range(5)] : 4'($urandom_range(15));
      for (int k = 0; k < 6; k++) rd[k] = 8'($urandom);
      apply(rr, re, rs, rd);
      model_step(rr, re, rs, rd);
      check_all(1000 + n, m_s, m_e, m_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
